// File: rtl/seg7_pkg.sv
// Shared 7-segment helpers for the board display blocks.
// Segment vectors are [0:7]: bit 0 = DP, bits 1..7 = g,f,e,d,c,b,a, all active-low.
package seg7_pkg;

    localparam logic [0:7] SEG_BLANK  = 8'hFF;
    localparam int         SEG_DP_BIT = 0;

    // dp = 1 lights the decimal point.
    function automatic logic [0:7] seg7_encode(input logic [3:0] value, input logic dp);
        logic [0:7] pat;
        case (value)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            4'hF: pat = 8'h8E;
            default: pat = SEG_BLANK;
        endcase
        pat[SEG_DP_BIT] = ~dp;
        return pat;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// One switch channel: 2-flop synchroniser followed by a hold-time debouncer.
// rise is a one-cycle strobe on the edge where stable commits 0->1.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int              CW   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync;
    logic [CW-1:0] cnt;
    logic          commit;

    // A new level is accepted only after sync has differed from stable for DEBOUNCE_CYCLES edges.
    assign commit = (sync != stable) && (cnt == LAST);
    assign rise   = commit && sync;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1  <= 1'b0;
            sync   <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync1 <= raw;
            sync  <= sync1;
            if ((sync == stable) || commit) cnt <= '0;
            else                            cnt <= cnt + CW'(1);
            if (commit) stable <= sync;
        end
    end

endmodule

// File: rtl/switch_count_display.sv
// Debounced switches drive LEDs; each channel's up-transition count is shown on its HEX digit.
// The digit's decimal point is lit while the debounced switch is up.
module switch_count_display
    import seg7_pkg::*;
#(
    parameter int CHANNELS        = 6,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DECIMAL         = 0
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [0:CHANNELS-1] SW,
    output logic [0:CHANNELS-1] LEDR,
    output logic [0:7]          HEX0,
    output logic [0:7]          HEX1,
    output logic [0:7]          HEX2,
    output logic [0:7]          HEX3,
    output logic [0:7]          HEX4,
    output logic [0:7]          HEX5
);

    logic [0:CHANNELS-1] rise;
    logic [0:7]          hex [6];

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [3:0] count;
        logic [0:7] digit;

        switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .CLOCK_50 (CLOCK_50),
            .reset    (reset),
            .raw      (SW[i]),
            .stable   (LEDR[i]),
            .rise     (rise[i])
        );

        // The digit trails count/stable by one edge so the segment decode is registered.
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                count <= 4'h0;
                digit <= 8'hC0;
            end else begin
                if (rise[i]) begin
                    if ((DECIMAL != 0) && (count == 4'd9)) count <= 4'h0;
                    else                                   count <= count + 4'h1;
                end
                digit <= seg7_encode(count, LEDR[i]);
            end
        end

        assign hex[i] = digit;
    end

    for (genvar i = CHANNELS; i < 6; i++) begin : g_blank
        assign hex[i] = SEG_BLANK;
    end

    assign HEX0 = hex[0];
    assign HEX1 = hex[1];
    assign HEX2 = hex[2];
    assign HEX3 = hex[3];
    assign HEX4 = hex[4];
    assign HEX5 = hex[5];

endmodule

// File: tb/tb_switch_count_display.sv
// Bench for switch_count_display: a hex 6-channel instance and a decimal 3-channel instance
// share clock, reset and the low switches; both are compared every cycle against a reference model.
module tb_switch_count_display;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:5] sw;
    logic [0:5] ledr_a;
    logic [0:2] ledr_b;
    logic [0:7] hex_a [6];
    logic [0:7] hex_b [6];

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // reference model state
    logic [0:5] sw_q   [$];
    logic [0:5] sync_q [$];
    logic [0:5] m_stable;
    int         n_rise  [6];
    logic [7:0] m_hex_a [6];
    logic [7:0] m_hex_b [3];

    always #5 clk = ~clk;

    switch_count_display #(.CHANNELS(6), .DEBOUNCE_CYCLES(D), .DECIMAL(0)) dut_a (
        .CLOCK_50 (clk),
        .reset    (rst),
        .SW       (sw),
        .LEDR     (ledr_a),
        .HEX0     (hex_a[0]),
        .HEX1     (hex_a[1]),
        .HEX2     (hex_a[2]),
        .HEX3     (hex_a[3]),
        .HEX4     (hex_a[4]),
        .HEX5     (hex_a[5])
    );

    switch_count_display #(.CHANNELS(3), .DEBOUNCE_CYCLES(D), .DECIMAL(1)) dut_b (
        .CLOCK_50 (clk),
        .reset    (rst),
        .SW       (sw[0:2]),
        .LEDR     (ledr_b),
        .HEX0     (hex_b[0]),
        .HEX1     (hex_b[1]),
        .HEX2     (hex_b[2]),
        .HEX3     (hex_b[3]),
        .HEX4     (hex_b[4]),
        .HEX5     (hex_b[5])
    );

    function automatic logic [7:0] exp_seg(int v, logic up);
        logic [7:0] p;
        p = seg_tab[v];
        if (up) p[7] = 1'b0;
        return p;
    endfunction

    task automatic model_reset();
        sw_q.delete();
        sync_q.delete();
        m_stable = '0;
        for (int i = 0; i < 6; i++) begin
            n_rise[i]  = 0;
            m_hex_a[i] = 8'hC0;
        end
        for (int i = 0; i < 3; i++) m_hex_b[i] = 8'hC0;
    endtask

    // One clock edge: a level is accepted once the synchronised switch (SW two edges ago)
    // has disagreed with the accepted level for the last D edges in a row.
    task automatic model_edge();
        logic [0:5] s;
        bit         flip;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 6; i++) m_hex_a[i] = exp_seg(n_rise[i] % 16, m_stable[i]);
        for (int i = 0; i < 3; i++) m_hex_b[i] = exp_seg(n_rise[i] % 10, m_stable[i]);
        s = (sw_q.size() >= 2) ? sw_q[0] : 6'b0;
        sync_q.push_back(s);
        if (sync_q.size() > D) void'(sync_q.pop_front());
        if (sync_q.size() == D) begin
            for (int ch = 0; ch < 6; ch++) begin
                flip = 1'b1;
                for (int k = 0; k < D; k++)
                    if (sync_q[k][ch] == m_stable[ch]) flip = 1'b0;
                if (flip) begin
                    m_stable[ch] = ~m_stable[ch];
                    if (m_stable[ch]) n_rise[ch]++;
                end
            end
        end
        sw_q.push_back(sw);
        if (sw_q.size() > 2) void'(sw_q.pop_front());
    endtask

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 6; i++) chk($sformatf("a_hex%0d", i), hex_a[i], m_hex_a[i]);
        chk("a_ledr", {2'b00, ledr_a}, {2'b00, m_stable});
        chk("b_ledr", {5'b00000, ledr_b}, {5'b00000, m_stable[0:2]});
        for (int i = 0; i < 3; i++) chk($sformatf("b_hex%0d", i), hex_b[i], m_hex_b[i]);
        for (int i = 3; i < 6; i++) chk($sformatf("b_blank%0d", i), hex_b[i], 8'hFF);
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw  = 6'h3F;
        model_reset();
        step(3);
        chk("rst_ledr", {2'b00, ledr_a}, 8'h00);
        for (int i = 0; i < 6; i++) chk($sformatf("rst_hex%0d", i), hex_a[i], 8'hC0);

        // switches held up through reset release
        rst = 1'b0;
        step(5);
        chk("ledr_before6", {2'b00, ledr_a}, 8'h00);
        step(1);
        chk("ledr_at6", {2'b00, ledr_a}, 8'h3F);
        step(1);
        for (int i = 0; i < 6; i++) chk($sformatf("hex_at7_%0d", i), hex_a[i], 8'h79);
        for (int i = 0; i < 3; i++) chk($sformatf("b_hex_at7_%0d", i), hex_b[i], 8'h79);

        // bounce shorter than the window, then a clean high
        sw = 6'h00;
        do_reset();
        step(4);
        sw[2] = 1'b1;
        step(3);
        sw[2] = 1'b0;
        step(10);
        chk("bounce_ledr2", {7'b0, ledr_a[2]}, 8'h00);
        chk("bounce_hex2", hex_a[2], 8'hC0);
        sw[2] = 1'b1;
        step(8);
        chk("clean_hex2", hex_a[2], 8'h79);

        // full wrap of the count on channel 0
        sw = 6'h00;
        do_reset();
        step(4);
        for (int t = 1; t <= 16; t++) begin
            sw[0] = 1'b1;
            step(7);
            sw[0] = 1'b0;
            step(7);
            if (t == 9)  chk("dec_nine", hex_b[0], 8'h90);
            if (t == 10) chk("dec_wrap", hex_b[0], 8'hC0);
            if (t == 15) chk("hex_f", hex_a[0], 8'h8E);
        end
        chk("hex_wrap", hex_a[0], 8'hC0);
        chk("dec_six", hex_b[0], 8'h82);

        // random switch activity, bounces included
        repeat (60) begin
            logic [31:0] r;
            r  = $urandom;
            sw = sw ^ (r[5:0] & r[11:6]);
            step($urandom_range(1, 8));
        end

        // asynchronous reset in the middle of a debounce window
        sw = 6'h00;
        do_reset();
        step(3);
        sw[1] = 1'b1;
        step(4);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_win_ledr", {2'b00, ledr_a}, 8'h00);
        check_all();
        step(2);
        sw  = 6'h00;
        rst = 1'b0;

        // asynchronous reset while HEX1 shows 5
        step(4);
        for (int t = 0; t < 5; t++) begin
            sw[1] = 1'b1;
            step(7);
            sw[1] = 1'b0;
            step(7);
        end
        chk("hex1_five", hex_a[1], 8'h92);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_cnt_hex1", hex_a[1], 8'hC0);
        check_all();
        step(2);
        rst = 1'b0;

        // simultaneous rises on the two outer channels
        step(4);
        sw[0] = 1'b1;
        sw[5] = 1'b1;
        step(6);
        chk("simul_ledr", {2'b00, ledr_a}, 8'h21);
        step(1);
        chk("simul_hex0", hex_a[0], 8'h79);
        chk("simul_hex5", hex_a[5], 8'h79);
        step(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
